step_onehot_monitor: RTL and testbench
======================================

// Module: step_onehot_monitor
// PURPOSE
//   Receive-side checker for the 29-phase one-hot step bus driven by the stepper.
//   Registers the bus, encodes it back to a binary index and confirms the sequence 0,1,..,28,0 advances once per clock.
//   Locks onto a correct sequence, counts full revolutions, and flags/counts one-hot and sequence violations.
//   Sits beside any consumer of the step bus as a self-test/diagnostic tap.
// PARAMETERS
//   N_STEPS     29  number of one-hot phases; index wraps N_STEPS-1 -> 0
//   IDX_W       5   index width, $clog2(N_STEPS)
//   LOCK_COUNT  3   consecutive correct advances needed to declare lock (>=1)
//   ALLOW_HOLD  0   1: a repeated index is a legal step (stepper enable low); 0: violation
// PORTS
//   clk          in   1        system clock, all state on rising edge
//   rst_n        in   1        asynchronous active-low reset
//   step_i       in   N_STEPS  one-hot step bus under test
//   clr_i        in   1        synchronous clear of sticky flags and err_cnt_o
//   idx_o        out  IDX_W    binary index of registered step bus
//   idx_valid_o  out  1        registered bus was exactly one-hot
//   locked_o     out  1        FSM in LOCKED
//   err_onehot_o out  1        sticky: zero or >1 bits set while LOCKED
//   err_seq_o    out  1        sticky: valid index but wrong successor while LOCKED
//   wrap_cnt_o   out  16       accepted N_STEPS-1 -> 0 transitions while LOCKED, modulo 2^16
//   err_cnt_o    out  8        violations while LOCKED, saturates at 255
// BEHAVIOUR
//   - Reset: all outputs 0, FSM = HUNT, run counter 0, step_q 0. Async assert, sync deassert.
//   - Stage 1: step_q <= step_i every cycle. Stage 2: idx_o/idx_valid_o <= encode(step_q).
//     Latency: step_i sampled at edge k -> idx_o at edge k+1. Invalid encode -> idx_o = 0.
//   - FSM evaluates encode(step_q) vs prev (last valid index) on the same edge as idx_o updates.
//   - nxt(prev) = (prev == N_STEPS-1) ? 0 : prev+1. Legal = valid && (idx == nxt(prev) || (ALLOW_HOLD && idx == prev)).
//   - HUNT: valid -> LOCKING, run=0, prev=idx. Invalid -> stay.
//   - LOCKING: legal -> run+1; when run+1 == LOCK_COUNT -> LOCKED. Valid but illegal -> stay,
//     run=0, prev=idx. Invalid -> HUNT. No flags/counters touched in HUNT/LOCKING.
//   - LOCKED: legal -> stay, prev=idx; if prev==N_STEPS-1 && idx==0 wrap_cnt_o+1 (hold not counted).
//     Not one-hot -> err_onehot_o=1. Valid but illegal -> err_seq_o=1. Either: err_cnt_o+1 (sat), -> HUNT.
//   - locked_o rises exactly LOCK_COUNT cycles after idx_valid_o first rises on a clean sequence.
//   - clr_i: clears err_onehot_o, err_seq_o, err_cnt_o; does not touch wrap_cnt_o or FSM.
//     clr_i with a violation in the same cycle: flag set, err_cnt_o = 1.
//   - Reset mid-operation: everything clears immediately; relock needs full HUNT/LOCKING pass.
// STRUCTURE
//   - Shared package step_pkg: N_STEPS, IDX_W, state enum {HUNT, LOCKING, LOCKED}, nxt function.
//   - Sub-module onehot_to_bin (combinational, N-wide): outputs idx and valid (exactly one bit set).
//   - Top: input register, output register, FSM, run counter, prev register, wrap/err counters.
// TESTING
//   1 Stepper drives step from reset -> idx_o tracks 0,1,2.. one cycle behind step_q; locked_o at
//     LOCK_COUNT cycles after idx_valid_o; after 29*10 cycles wrap_cnt_o == 9 or 10 per lock point, no errors.
//   2 While LOCKED force step_i = 0 one cycle -> err_onehot_o=1, err_cnt_o=1, locked_o=0, idx_valid_o=0;
//     stepper resumes -> relock after LOCK_COUNT cycles, flag stays set.
//   3 While LOCKED inject index 5 after 2 -> err_seq_o=1, err_cnt_o=1, HUNT; inject 3 bits set -> err_onehot_o.
//   4 Repeat index with ALLOW_HOLD=0 -> err_seq_o; with ALLOW_HOLD=1 -> stays locked, wrap_cnt_o unchanged.
//   5 300 violations -> err_cnt_o == 255; clr_i with simultaneous violation -> err_cnt_o == 1, flag set.
//   6 Assert rst_n low mid-sequence (idx 17) -> all outputs 0 same cycle; release -> relock from HUNT.

Source files
------------

// File: rtl/step_pkg.sv
// Shared definitions for the one-hot step bus: phase count, index width,
// monitor FSM states and the successor function for the phase sequence.
package step_pkg;

  localparam int N_STEPS = 29;
  localparam int IDX_W   = $clog2(N_STEPS);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Expected successor of a phase index; wraps from the last phase to 0.
  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] prev);
    if (prev == IDX_W'(N_STEPS - 1)) return '0;
    return prev + IDX_W'(1);
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary encoder. valid is high only when exactly
// one bit is set; idx is meaningful only while valid is high.
module onehot_to_bin
  import step_pkg::*;
#(
  parameter int N = N_STEPS,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = idx | W'(i);
    end
    // Clearing the lowest set bit leaves zero only for a single-bit word.
    valid = (onehot != '0) && ((onehot & (onehot - N'(1))) == '0);
  end

endmodule

// File: rtl/step_onehot_monitor.sv
// Receive-side checker for the one-hot step bus: registers and encodes the
// bus, locks onto a clean 0..N_STEPS-1 sequence, counts wraps and violations.
module step_onehot_monitor
  import step_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int ALLOW_HOLD = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_STEPS-1:0] step_i,
  input  logic               clr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               idx_valid_o,
  output logic               locked_o,
  output logic               err_onehot_o,
  output logic               err_seq_o,
  output logic [15:0]        wrap_cnt_o,
  output logic [7:0]         err_cnt_o,
  output state_t             state_o
);

  localparam int             RUN_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W:0] LOCK_TGT = (RUN_W + 1)'(LOCK_COUNT);
  localparam logic           HOLD_EN  = (ALLOW_HOLD != 0);

  logic [N_STEPS-1:0] step_q;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_valid;
  logic [IDX_W-1:0]   prev;
  logic [RUN_W-1:0]   run;

  logic [RUN_W:0]     run_inc;
  logic               is_next;
  logic               is_hold;
  logic               legal;
  logic               is_wrap;
  logic [7:0]         err_base;
  logic [7:0]         err_inc;

  onehot_to_bin #(
    .N (N_STEPS),
    .W (IDX_W)
  ) u_enc (
    .onehot (step_q),
    .idx    (enc_idx),
    .valid  (enc_valid)
  );

  always_comb begin
    run_inc  = {1'b0, run} + (RUN_W + 1)'(1);
    is_next  = enc_valid && (enc_idx == nxt(prev));
    is_hold  = HOLD_EN && enc_valid && (enc_idx == prev);
    legal    = is_next || is_hold;
    // A hold at the last phase is not a wrap: only a true advance counts.
    is_wrap  = is_next && (prev == IDX_W'(N_STEPS - 1));
    // A clear in the same cycle as a violation restarts the count at one.
    err_base = clr_i ? 8'd0 : err_cnt_o;
    err_inc  = (err_base == 8'hff) ? 8'hff : err_base + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q       <= '0;
      idx_o        <= '0;
      idx_valid_o  <= 1'b0;
      locked_o     <= 1'b0;
      err_onehot_o <= 1'b0;
      err_seq_o    <= 1'b0;
      wrap_cnt_o   <= '0;
      err_cnt_o    <= '0;
      state_o      <= HUNT;
      prev         <= '0;
      run          <= '0;
    end else begin
      step_q      <= step_i;
      idx_o       <= enc_valid ? enc_idx : '0;
      idx_valid_o <= enc_valid;

      if (clr_i) begin
        err_onehot_o <= 1'b0;
        err_seq_o    <= 1'b0;
        err_cnt_o    <= '0;
      end

      case (state_o)
        HUNT: begin
          if (enc_valid) begin
            state_o <= LOCKING;
            run     <= '0;
            prev    <= enc_idx;
          end
        end

        LOCKING: begin
          if (legal) begin
            prev <= enc_idx;
            if (run_inc == LOCK_TGT) begin
              state_o  <= LOCKED;
              locked_o <= 1'b1;
              run      <= '0;
            end else begin
              run <= run_inc[RUN_W-1:0];
            end
          end else if (enc_valid) begin
            run  <= '0;
            prev <= enc_idx;
          end else begin
            state_o <= HUNT;
          end
        end

        LOCKED: begin
          if (legal) begin
            prev <= enc_idx;
            if (is_wrap) wrap_cnt_o <= wrap_cnt_o + 16'd1;
          end else begin
            state_o   <= HUNT;
            locked_o  <= 1'b0;
            err_cnt_o <= err_inc;
            if (!enc_valid) err_onehot_o <= 1'b1;
            else            err_seq_o    <= 1'b1;
          end
        end

        default: begin
          state_o  <= HUNT;
          locked_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_onehot_monitor.sv
// Bench for step_onehot_monitor: a strict instance and a hold-tolerant
// instance share one stimulus stream and are compared against a streak model.
module tb_step_onehot_monitor;
  import step_pkg::*;

  localparam int LC = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clr_i = 1'b0;
  logic [N_STEPS-1:0] step_i = '0;

  logic [IDX_W-1:0] o_idx    [2];
  logic             o_valid  [2];
  logic             o_locked [2];
  logic             o_eoh    [2];
  logic             o_eseq   [2];
  logic [15:0]      o_wrap   [2];
  logic [7:0]       o_ecnt   [2];
  state_t           o_state  [2];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;
  int ph      = 0;

  // Reference model: a streak counter per instance (-1 = no anchor yet)
  logic [N_STEPS-1:0] m_stepq;
  int m_anchor [2];
  int m_streak [2];
  int m_idx    [2];
  bit m_valid  [2];
  bit m_eoh    [2];
  bit m_eseq   [2];
  int m_wrap   [2];
  int m_ecnt   [2];

  typedef struct {
    logic [N_STEPS-1:0] bus;
    int                 exp_idx;
    bit                 exp_valid;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  step_onehot_monitor #(.LOCK_COUNT(LC), .ALLOW_HOLD(0)) dut (
    .clk(clk), .rst_n(rst_n), .step_i(step_i), .clr_i(clr_i),
    .idx_o(o_idx[0]), .idx_valid_o(o_valid[0]), .locked_o(o_locked[0]),
    .err_onehot_o(o_eoh[0]), .err_seq_o(o_eseq[0]), .wrap_cnt_o(o_wrap[0]),
    .err_cnt_o(o_ecnt[0]), .state_o(o_state[0])
  );

  step_onehot_monitor #(.LOCK_COUNT(LC), .ALLOW_HOLD(1)) dut_h (
    .clk(clk), .rst_n(rst_n), .step_i(step_i), .clr_i(clr_i),
    .idx_o(o_idx[1]), .idx_valid_o(o_valid[1]), .locked_o(o_locked[1]),
    .err_onehot_o(o_eoh[1]), .err_seq_o(o_eseq[1]), .wrap_cnt_o(o_wrap[1]),
    .err_cnt_o(o_ecnt[1]), .state_o(o_state[1])
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_m(input string name, input int m, input longint act, input longint exp);
    check($sformatf("%s[%0d]", name, m), act, exp);
  endtask

  function automatic int bus_index(input logic [N_STEPS-1:0] b);
    for (int i = 0; i < N_STEPS; i++) if (b[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_stepq = '0;
    for (int m = 0; m < 2; m++) begin
      m_anchor[m] = 0; m_streak[m] = -1; m_idx[m] = 0; m_valid[m] = 0;
      m_eoh[m] = 0; m_eseq[m] = 0; m_wrap[m] = 0; m_ecnt[m] = 0;
    end
  endtask

  task automatic model_update(input int m);
    bit v, legal, was_locked;
    int ix;
    v  = ($countones(m_stepq) == 1);
    ix = v ? bus_index(m_stepq) : 0;
    legal = v && (m_streak[m] >= 0) &&
            ((ix == (m_anchor[m] + 1) % N_STEPS) || (m == 1 && ix == m_anchor[m]));
    was_locked = (m_streak[m] >= LC);
    if (clr_i) begin
      m_eoh[m] = 0; m_eseq[m] = 0; m_ecnt[m] = 0;
    end
    if (was_locked) begin
      if (legal) begin
        if (m_anchor[m] == N_STEPS - 1 && ix == 0) m_wrap[m] = (m_wrap[m] + 1) % 65536;
        m_anchor[m] = ix;
      end else begin
        if (!v) m_eoh[m] = 1; else m_eseq[m] = 1;
        m_ecnt[m]   = (m_ecnt[m] >= 255) ? 255 : m_ecnt[m] + 1;
        m_streak[m] = -1;
      end
    end else if (m_streak[m] < 0) begin
      if (v) begin m_anchor[m] = ix; m_streak[m] = 0; end
    end else if (legal) begin
      m_anchor[m] = ix; m_streak[m] = m_streak[m] + 1;
    end else if (v) begin
      m_anchor[m] = ix; m_streak[m] = 0;
    end else begin
      m_streak[m] = -1;
    end
    m_idx[m]   = ix;
    m_valid[m] = v;
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n) begin
      for (int m = 0; m < 2; m++) model_update(m);
      m_stepq = step_i;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        check_m("idx", m, o_idx[m], m_idx[m]);
        check_m("idx_valid", m, o_valid[m], m_valid[m]);
        check_m("locked", m, o_locked[m], m_streak[m] >= LC);
        check_m("state_locked", m, o_state[m] == LOCKED, m_streak[m] >= LC);
        check_m("err_onehot", m, o_eoh[m], m_eoh[m]);
        check_m("err_seq", m, o_eseq[m], m_eseq[m]);
        check_m("wrap_cnt", m, o_wrap[m], m_wrap[m]);
        check_m("err_cnt", m, o_ecnt[m], m_ecnt[m]);
      end
    end
  end

  task automatic cyc(input logic [N_STEPS-1:0] s, input logic c);
    @(negedge clk);
    #2;
    step_i = s;
    clr_i  = c;
  endtask

  task automatic step1(input logic c = 1'b0);
    cyc(N_STEPS'(1) << ph, c);
    ph = (ph + 1) % N_STEPS;
  endtask

  task automatic lock_latency(input string name);
    int tv, tl;
    tv = -1; tl = -1;
    for (int i = 0; i < 20; i++) begin
      step1();
      if (tv < 0 && o_valid[0]) tv = i;
      if (tl < 0 && o_locked[0]) tl = i;
    end
    check(name, tl - tv, LC);
  endtask

  task automatic check_all_zero(input string name);
    for (int m = 0; m < 2; m++) begin
      check_m({name, "_idx"}, m, o_idx[m], 0);
      check_m({name, "_valid"}, m, o_valid[m], 0);
      check_m({name, "_locked"}, m, o_locked[m], 0);
      check_m({name, "_eoh"}, m, o_eoh[m], 0);
      check_m({name, "_eseq"}, m, o_eseq[m], 0);
      check_m({name, "_wrap"}, m, o_wrap[m], 0);
      check_m({name, "_ecnt"}, m, o_ecnt[m], 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d, found;
    logic [N_STEPS-1:0] bus;

    vecs[0] = '{N_STEPS'(1),        0,  1'b1};
    vecs[1] = '{N_STEPS'(1) << 28,  28, 1'b1};
    vecs[2] = '{N_STEPS'(0),        0,  1'b0};
    vecs[3] = '{N_STEPS'(3),        0,  1'b0};
    vecs[4] = '{N_STEPS'(1) << 13,  13, 1'b1};
    vecs[5] = '{{N_STEPS{1'b1}},    0,  1'b0};
    vecs[6] = '{(N_STEPS'(1) << 28) | N_STEPS'(2), 0, 1'b0};
    vecs[7] = '{N_STEPS'(1) << 27,  27, 1'b1};

    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    check_all_zero("reset");

    // 1: clean stepping from reset, lock latency and revolution count
    @(negedge clk);
    #2;
    rst_n  = 1'b1;
    step_i = N_STEPS'(1);
    ph     = 1;
    lock_latency("lock_latency");
    w0 = o_wrap[0];
    repeat (290) step1();
    d = int'(o_wrap[0]) - w0;
    check("wrap_10rev", (d == 9 || d == 10) ? d : -d, d);
    check("clean_err_cnt", o_ecnt[0], 0);

    // 2: one all-zero cycle while locked
    cyc('0, 1'b0);
    ph = (ph + 1) % N_STEPS;
    step1(); step1();
    check("zero_eoh", o_eoh[0], 1);
    check("zero_ecnt", o_ecnt[0], 1);
    check("zero_locked", o_locked[0], 0);
    check("zero_valid", o_valid[0], 0);
    repeat (LC + 1) step1();
    check("zero_relock", o_locked[0], 1);
    check("zero_eoh_sticky", o_eoh[0], 1);

    // 3: index 5 after 2, then three bits set
    step1(1'b1);
    for (int i = 0; i < N_STEPS && ph != 3; i++) step1();
    cyc(N_STEPS'(1) << 5, 1'b0);
    ph = 6;
    step1(); step1();
    check("seq_eseq", o_eseq[0], 1);
    check("seq_ecnt", o_ecnt[0], 1);
    check("seq_locked", o_locked[0], 0);
    check("seq_eoh", o_eoh[0], 0);
    repeat (LC + 3) step1();
    check("seq_relock", o_locked[0], 1);
    bus = N_STEPS'(29'h0010_0101);
    cyc(bus, 1'b0);
    ph = (ph + 1) % N_STEPS;
    step1(); step1();
    check("multi_eoh", o_eoh[0], 1);
    check("multi_ecnt", o_ecnt[0], 2);
    check("multi_locked", o_locked[0], 0);

    // 4: repeated index, strict versus hold-tolerant
    step1(1'b1);
    repeat (LC + 3) step1();
    for (int i = 0; i < N_STEPS && (ph < 5 || ph > 20); i++) step1();
    w0 = o_wrap[1];
    cyc(N_STEPS'(1) << ((ph + N_STEPS - 1) % N_STEPS), 1'b0);
    step1(); step1();
    check("hold_strict_eseq", o_eseq[0], 1);
    check("hold_strict_locked", o_locked[0], 0);
    check("hold_tol_locked", o_locked[1], 1);
    check("hold_tol_eseq", o_eseq[1], 0);
    check("hold_tol_wrap", o_wrap[1], w0);
    check("hold_tol_ecnt", o_ecnt[1], 0);

    // 5: saturation, then clear coinciding with a violation
    for (int i = 0; i < 300; i++) begin
      repeat (5) step1();
      cyc('0, 1'b0);
      ph = (ph + 1) % N_STEPS;
    end
    step1(); step1();
    check("sat_ecnt", o_ecnt[0], 255);
    check("sat_ecnt_h", o_ecnt[1], 255);
    repeat (6) step1();
    check("sat_relock", o_locked[0], 1);
    cyc('0, 1'b0);
    ph = (ph + 1) % N_STEPS;
    step1(1'b1);
    step1();
    check("clr_viol_ecnt", o_ecnt[0], 1);
    check("clr_viol_eoh", o_eoh[0], 1);
    check("clr_viol_eseq", o_eseq[0], 0);

    // 6: asynchronous reset at index 17
    repeat (6) step1();
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step1();
      if (o_idx[0] == IDX_W'(17) && o_locked[0]) found = 1;
    end
    check("reach_idx17", found, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) step1();
    rst_n = 1'b1;
    lock_latency("relock_latency");

    // decode table
    for (int i = 0; i < 8; i++) begin
      repeat (3) cyc(vecs[i].bus, 1'b0);
      check($sformatf("vec%0d_idx", i), o_idx[0], vecs[i].exp_idx);
      check($sformatf("vec%0d_valid", i), o_valid[0], vecs[i].exp_valid);
    end

    // randomized stepping with injected faults, checked against the model
    for (int i = 0; i < 2000; i++) begin
      int r;
      logic c;
      r = $urandom_range(0, 99);
      c = ($urandom_range(0, 99) < 3);
      if (r < 80) begin
        step1(c);
      end else if (r < 86) begin
        cyc(N_STEPS'(1) << ((ph + N_STEPS - 1) % N_STEPS), c);
      end else if (r < 92) begin
        int k;
        k = $urandom_range(0, N_STEPS - 1);
        cyc(N_STEPS'(1) << k, c);
        ph = (k + 1) % N_STEPS;
      end else if (r < 96) begin
        cyc('0, c);
      end else begin
        cyc(N_STEPS'($urandom), c);
      end
    end
    repeat (3) step1();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
